// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller and alu_32: ALU codes, opcodes, states, causes.
// Pure declarations; no timing or flow-control behaviour of its own.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'h0,
    ALU_OR   = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_ADDU = 4'h3,
    ALU_SUB  = 4'h6,
    ALU_SLT  = 4'h7,
    ALU_NOR  = 4'hC,
    ALU_BAD  = 4'hF
  } alu_ctrl_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BRANCH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU  = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP = 2'b01;
  localparam logic [1:0] PC_SRC_EXC  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WRITE, S_MEM_WB, S_BR_CMP, S_BR_TGT, S_BR_TAKE, S_JUMP, S_EXC
  } state_e;

  typedef enum logic [1:0] {
    EXC_RESERVED = 2'b00,
    EXC_OVERFLOW = 2'b01,
    EXC_INVALID  = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } exc_cause_e;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       exception;
  } ctrl_t;

  function automatic logic is_mem_wait(state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/alu_control_decode.sv
// R-type funct field to 4-bit alu_32 control code; unknown functs map to the unsupported code F.
// Purely combinational, no handshake.
module alu_control_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_BAD;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_ADDU: alu_control = ALU_ADDU;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_NOR:  alu_control = ALU_NOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: alu_control = ALU_BAD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: strobes are registered from the next state, one cycle per state.
// Memory states stall on mem_ready (optionally bounded by MEM_TIMEOUT); ALU flags are read one state after issue.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TIMEOUT_W   = 8,
  parameter bit          OVF_TRAP    = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_invalid,
  output logic [3:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       exception,
  output logic [1:0] exc_cause
);

  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_e                 state_q, state_d;
  ctrl_t                  ctrl_q, ctrl_d;
  exc_cause_e             exc_cause_q, exc_cause_d;
  logic [TIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [3:0]             dec_alu_control;
  logic                   timeout_hit;
  logic                   r_ovf_trap;
  logic                   i_ovf_trap;
  logic                   wb_trap;

  alu_control_decode u_alu_control_decode (
    .funct       (funct),
    .alu_control (dec_alu_control)
  );

  assign timeout_hit = (MEM_TIMEOUT != 0) && is_mem_wait(state_q) && !mem_ready
                       && (tmo_cnt_q == TMO_LIMIT);
  assign r_ovf_trap  = OVF_TRAP && alu_overflow && (funct == FN_ADD);
  assign i_ovf_trap  = OVF_TRAP && alu_overflow;

  // Flags only arrive in the write-back cycle itself, so the registered write strobe is vetoed there.
  assign wb_trap = ((state_q == S_R_WB) && (alu_invalid || r_ovf_trap))
                || ((state_q == S_I_WB) && i_ovf_trap);

  always_comb begin
    state_d     = state_q;
    exc_cause_d = exc_cause_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d     = S_EXC;
          exc_cause_d = EXC_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BR_CMP;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          default: begin
            state_d     = S_EXC;
            exc_cause_d = EXC_RESERVED;
          end
        endcase
      end
      S_R_EXEC: state_d = S_R_WB;
      S_R_WB: begin
        state_d = S_FETCH;
        if (alu_invalid) begin
          state_d     = S_EXC;
          exc_cause_d = EXC_INVALID;
        end else if (r_ovf_trap) begin
          state_d     = S_EXC;
          exc_cause_d = EXC_OVERFLOW;
        end
      end
      S_I_EXEC: state_d = S_I_WB;
      S_I_WB: begin
        state_d = S_FETCH;
        if (i_ovf_trap) begin
          state_d     = S_EXC;
          exc_cause_d = EXC_OVERFLOW;
        end
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ, S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = (state_q == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d     = S_EXC;
          exc_cause_d = EXC_TIMEOUT;
        end
      end
      S_MEM_WB: state_d = S_FETCH;
      S_BR_CMP: state_d = S_BR_TGT;
      // Reaching BR_TAKE is the latched branch decision.
      S_BR_TGT: state_d = alu_zero ? S_BR_TAKE : S_FETCH;
      S_BR_TAKE, S_JUMP, S_EXC: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (is_mem_wait(state_d) && (state_d != state_q)) begin
      tmo_cnt_d = '0;
    end else if (is_mem_wait(state_q) && !mem_ready && (tmo_cnt_q != '1)) begin
      tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
    end
  end

  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.alu_control = ALU_ADD;
        ctrl_d.alu_src_b   = SRC_B_FOUR;
        ctrl_d.mem_read    = 1'b1;
        ctrl_d.ir_write    = 1'b1;
      end
      S_DECODE: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = PC_SRC_ALU;
      end
      S_R_EXEC: begin
        ctrl_d.alu_control = dec_alu_control;
        ctrl_d.alu_src_a   = 1'b1;
        ctrl_d.alu_src_b   = SRC_B_REG;
      end
      S_R_WB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
      end
      S_I_EXEC, S_MEM_ADDR: begin
        ctrl_d.alu_control = ALU_ADD;
        ctrl_d.alu_src_a   = 1'b1;
        ctrl_d.alu_src_b   = SRC_B_IMM;
      end
      S_I_WB: ctrl_d.reg_write = 1'b1;
      S_MEM_READ: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_BR_CMP: begin
        ctrl_d.alu_control = ALU_SUB;
        ctrl_d.alu_src_a   = 1'b1;
        ctrl_d.alu_src_b   = SRC_B_REG;
      end
      S_BR_TGT: begin
        ctrl_d.alu_control = ALU_ADD;
        ctrl_d.alu_src_b   = SRC_B_BRANCH;
      end
      S_BR_TAKE: ctrl_d.pc_write = 1'b1;
      S_JUMP: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = PC_SRC_JUMP;
      end
      S_EXC: begin
        ctrl_d.exception = 1'b1;
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = PC_SRC_EXC;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      exc_cause_q <= EXC_RESERVED;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      exc_cause_q <= exc_cause_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign alu_control = ctrl_q.alu_control;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign ir_write    = ctrl_q.ir_write;
  assign i_or_d      = ctrl_q.i_or_d;
  assign reg_write   = ctrl_q.reg_write & ~wb_trap;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign pc_write    = ctrl_q.pc_write;
  assign pc_source   = ctrl_q.pc_source;
  assign exception   = ctrl_q.exception;
  assign exc_cause   = exc_cause_q;

endmodule
